csr_issue: RTL and testbench
============================

// Module: csr_issue
// PURPOSE
//  Requester side of the CSR read/write port. Takes one Zicsr instruction (CSRRW/S/C, CSRRWI/SI/CI) from execute,
//  drives addr/write/data_in for exactly one cycle, captures read data and error, and returns rd data or an
//  illegal-instruction exception to writeback over a valid/ready handshake. One instruction in flight.
// PARAMETERS
//  none (CSR address width 12, data width 32 fixed by the CSR port)
// PORTS
//  clk          in   1      clock
//  reset        in   1      asynchronous, active-high reset
//  req_valid    in   1      CSR instruction offered
//  req_ready    out  1      block accepts instruction (high only in IDLE)
//  req_insn     in   32     raw instruction: csr=[31:20] rs1/uimm=[19:15] funct3=[14:12] rd=[11:7]
//  req_rs1      in   32     rs1 register value
//  req_pc       in   30     instruction PC [31:2]
//  req_kill     in   1      abort a not-yet-issued instruction
//  pipe_empty   in   1      no older instruction in flight (used only with CSR_SERIALIZE_EN)
//  csr_addr     out  12     CSR address
//  csr_write    out  2      00 none, 01 write, 10 set, 11 clear
//  csr_wdata    out  32     operand
//  csr_error    in   1      CSR port error (unimplemented / read-only write)
//  csr_rdata    in   32     CSR pre-write value
//  rsp_valid    out  1      response available
//  rsp_ready    in   1      writeback accepts response
//  rsp_rd       out  5      destination reg (0 on exception)
//  rsp_data     out  32     old CSR value for rd
//  rsp_exc      out  1      exception flag
//  rsp_cause    out  ecause_t  IILLEGAL when rsp_exc
//  rsp_tval     out  32     req_insn on exception, else 0
//  flush        out  1      one-cycle refetch pulse (CSR_SERIALIZE_EN only; else tied 0)
//  flush_pc     out  30     req_pc+1 when flush
// BEHAVIOUR
//  States: IDLE, DRAIN, ISSUE, RESP. Reset: IDLE; every output 0 except req_ready=1.
//  IDLE: req_ready=1; req_valid latches insn/rs1/pc -> ISSUE (DRAIN if CSR_SERIALIZE_EN).
//  Decode: funct3 000/100 illegal -> skip ISSUE, go RESP with rsp_exc=1, cause IILLEGAL, tval=insn.
//  Operand: funct3[2]=0 -> req_rs1; funct3[2]=1 -> {27'b0,uimm}.
//  Op: RW/RWI -> 01 always; RS/RSI -> 10, RC/RCI -> 11, but 00 when rs1 field==0 (no write, pure read).
//  ISSUE: exactly one cycle; csr_addr/csr_write/csr_wdata valid; csr_write=00 in every other state.
//   Capture csr_rdata (pre-write value) and csr_error at the closing edge -> RESP.
//   csr_error -> rsp_exc=1, IILLEGAL, tval=insn, rsp_rd=0. Else rsp_rd=rd, rsp_data=rdata (rd=0 passes as 0).
//  RESP: rsp_* held stable while rsp_valid && !rsp_ready; handshake -> IDLE. No accept in same cycle.
//  Latency (no macro): accept edge N, ISSUE cycle N+1, rsp_valid from N+2; throughput 1 per 3 cycles min.
//  req_kill: in DRAIN -> IDLE, no ISSUE, no response; in ISSUE/RESP ignored (side effect committed).
//  Async reset in any state: immediate IDLE; pending response and any unsampled write dropped.
// CONFIGURATION
//  CSR_SERIALIZE_EN defined: accept -> DRAIN; stay until pipe_empty=1 (or req_kill), then ISSUE next cycle.
//   On RESP handshake without exception, flush=1 for one cycle, flush_pc=req_pc+1.
//  Undefined: DRAIN unreachable, pipe_empty ignored, flush/flush_pc constant 0.
// STRUCTURE
//  Shared package: csr_op_t (CSR_NONE/WRITE/SET/CLEAR = 00/01/10/11), funct3 constants F3_CSRRW..F3_CSRRCI,
//   state enum csr_issue_state_t; ecause_t already there.
//  Sub-module csr_op_decode: combinational insn -> {csr_op_t, operand, illegal}; FSM and regs in csr_issue.
// TESTING
//  CSRRW x5, 0x340, rs1=0xDEADBEEF, mscratch=0x11 -> ISSUE write=01 wdata=DEADBEEF; rsp_rd=5 rsp_data=0x11.
//  CSRRS x3, 0x300, rs1 field=x0 -> csr_write=00 in ISSUE; rsp_data=mstatus 0x1800.
//  CSRRCI x1, 0x300, uimm=8 -> write=11 wdata=0x8; rsp_data=prior mstatus, MIE cleared.
//  CSRRW x2, 0xC00 (read-only) -> csr_error; rsp_exc=1 cause IILLEGAL tval=insn rsp_rd=0.
//  rsp_ready low 5 cycles -> rsp_* stable, req_ready=0, no second ISSUE; reset mid-RESP -> all outputs 0.
//  CSR_SERIALIZE_EN: pipe_empty low 4 cycles then high -> ISSUE next cycle; flush 1 cycle, flush_pc=pc+1; kill in DRAIN -> no rsp.

Source files
------------

// File: rtl/csr_issue_pkg.sv
// Shared types for the CSR issue block.
//   csr_op_t          : operation presented on csr_write (none/write/set/clear)
//   F3_CSRR*          : Zicsr funct3 encodings
//   csr_issue_state_t : issue FSM states
//   ecause_t          : exception cause codes returned to writeback
package csr_issue_pkg;

  localparam int CSR_AW = 12;
  localparam int CSR_DW = 32;

  typedef enum logic [1:0] {
    CSR_NONE  = 2'b00,
    CSR_WRITE = 2'b01,
    CSR_SET   = 2'b10,
    CSR_CLEAR = 2'b11
  } csr_op_t;

  localparam logic [2:0] F3_CSRRW  = 3'b001;
  localparam logic [2:0] F3_CSRRS  = 3'b010;
  localparam logic [2:0] F3_CSRRC  = 3'b011;
  localparam logic [2:0] F3_CSRRWI = 3'b101;
  localparam logic [2:0] F3_CSRRSI = 3'b110;
  localparam logic [2:0] F3_CSRRCI = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DRAIN,
    ST_ISSUE,
    ST_RESP
  } csr_issue_state_t;

  // Code 0 doubles as the idle value of rsp_cause when no exception is reported.
  typedef enum logic [3:0] {
    IMISALIGN = 4'd0,
    IACCESS   = 4'd1,
    IILLEGAL  = 4'd2,
    BREAKPT   = 4'd3,
    ECALL_M   = 4'd11
  } ecause_t;

endpackage

// File: rtl/csr_issue_if.sv
// CSR read/write port between the issue block (master) and the CSR file (slave).
//   csr_addr  : CSR address
//   csr_write : operation, CSR_NONE outside the single issue cycle
//   csr_wdata : operand
//   csr_error : unimplemented CSR or write to read-only CSR
//   csr_rdata : pre-write CSR value
interface csr_issue_if;
  import csr_issue_pkg::*;

  logic [CSR_AW-1:0] csr_addr;
  csr_op_t           csr_write;
  logic [CSR_DW-1:0] csr_wdata;
  logic              csr_error;
  logic [CSR_DW-1:0] csr_rdata;

  modport master (output csr_addr, csr_write, csr_wdata, input csr_error, csr_rdata);
  modport slave  (input csr_addr, csr_write, csr_wdata, output csr_error, csr_rdata);
endinterface

// File: rtl/csr_op_decode.sv
// Combinational Zicsr decode.
//   funct3    : instruction funct3
//   rs1_field : rs1 index / uimm field
//   rs1_val   : rs1 register value
//   op        : CSR operation (set/clear with a zero rs1 field become pure reads)
//   operand   : rs1 value or zero-extended uimm
//   illegal   : funct3 000/100 (not a CSR instruction)
module csr_op_decode
  import csr_issue_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [4:0]  rs1_field,
  input  logic [31:0] rs1_val,
  output csr_op_t     op,
  output logic [31:0] operand,
  output logic        illegal
);

  always_comb begin
    op      = CSR_NONE;
    illegal = 1'b0;
    operand = funct3[2] ? {27'b0, rs1_field} : rs1_val;
    case (funct3)
      F3_CSRRW, F3_CSRRWI: op = CSR_WRITE;
      F3_CSRRS, F3_CSRRSI: op = (rs1_field != 5'd0) ? CSR_SET : CSR_NONE;
      F3_CSRRC, F3_CSRRCI: op = (rs1_field != 5'd0) ? CSR_CLEAR : CSR_NONE;
      default:             illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/csr_issue.sv
// Requester side of the CSR port: accepts one Zicsr instruction, issues it on
// the CSR port for exactly one cycle and returns rd data or an illegal-
// instruction exception to writeback. One instruction in flight.
// Ports:
//   clk, reset            : clock, asynchronous active-high reset
//   req_*                 : instruction from execute (valid/ready, insn, rs1, pc, kill)
//   pipe_empty            : no older instruction in flight (serialising build only)
//   csr                   : CSR port (master side)
//   rsp_*                 : response to writeback (valid/ready, rd, data, exc, cause, tval)
//   flush, flush_pc       : refetch pulse after a completed CSR op (serialising build only)
// Optional feature: define CSR_SERIALIZE_EN to wait in DRAIN for pipe_empty
// before issuing and to request a refetch afterwards.
module csr_issue
  import csr_issue_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_insn,
  input  logic [31:0] req_rs1,
  input  logic [29:0] req_pc,
  input  logic        req_kill,
  input  logic        pipe_empty,
  csr_issue_if.master csr,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [4:0]  rsp_rd,
  output logic [31:0] rsp_data,
  output logic        rsp_exc,
  output ecause_t     rsp_cause,
  output logic [31:0] rsp_tval,
  output logic        flush,
  output logic [29:0] flush_pc
);

  csr_issue_state_t state_q;
  logic        req_ready_q;
  logic [31:0] insn_q;
  logic [31:0] rs1_q;
  logic [11:0] csr_addr_q;
  csr_op_t     csr_write_q;
  logic [31:0] csr_wdata_q;
  logic        rsp_valid_q;
  logic [4:0]  rsp_rd_q;
  logic [31:0] rsp_data_q;
  logic        rsp_exc_q;
  ecause_t     rsp_cause_q;
  logic [31:0] rsp_tval_q;

  // In IDLE decode straight from the request port so the CSR port registers
  // can be loaded on the accept edge; later states decode the latched copy.
  logic        idle_w;
  logic [2:0]  dec_funct3_d;
  logic [4:0]  dec_rs1f_d;
  logic [31:0] dec_rs1_d;
  logic [11:0] dec_addr_d;
  csr_op_t     dec_op;
  logic [31:0] dec_operand;
  logic        dec_illegal;

  assign idle_w       = (state_q == ST_IDLE);
  assign dec_funct3_d = idle_w ? req_insn[14:12] : insn_q[14:12];
  assign dec_rs1f_d   = idle_w ? req_insn[19:15] : insn_q[19:15];
  assign dec_addr_d   = idle_w ? req_insn[31:20] : insn_q[31:20];
  assign dec_rs1_d    = idle_w ? req_rs1 : rs1_q;

  csr_op_decode u_decode (
    .funct3    (dec_funct3_d),
    .rs1_field (dec_rs1f_d),
    .rs1_val   (dec_rs1_d),
    .op        (dec_op),
    .operand   (dec_operand),
    .illegal   (dec_illegal)
  );

`ifdef CSR_SERIALIZE_EN
  logic [29:0] pc_q;
  logic        flush_q;
  logic [29:0] flush_pc_q;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      req_ready_q <= 1'b1;
      insn_q      <= '0;
      rs1_q       <= '0;
      csr_addr_q  <= '0;
      csr_write_q <= CSR_NONE;
      csr_wdata_q <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rd_q    <= '0;
      rsp_data_q  <= '0;
      rsp_exc_q   <= 1'b0;
      rsp_cause_q <= IMISALIGN;
      rsp_tval_q  <= '0;
`ifdef CSR_SERIALIZE_EN
      pc_q        <= '0;
      flush_q     <= 1'b0;
      flush_pc_q  <= '0;
`endif
    end else begin
`ifdef CSR_SERIALIZE_EN
      flush_q <= 1'b0;
`endif
      case (state_q)
        ST_IDLE: begin
          if (req_valid) begin
            insn_q      <= req_insn;
            rs1_q       <= req_rs1;
            req_ready_q <= 1'b0;
`ifdef CSR_SERIALIZE_EN
            pc_q        <= req_pc;
`endif
            if (dec_illegal) begin
              // Not a CSR instruction: nothing to order against, answer at once.
              state_q     <= ST_RESP;
              rsp_valid_q <= 1'b1;
              rsp_exc_q   <= 1'b1;
              rsp_cause_q <= IILLEGAL;
              rsp_tval_q  <= req_insn;
              rsp_rd_q    <= '0;
              rsp_data_q  <= '0;
            end else begin
`ifdef CSR_SERIALIZE_EN
              state_q     <= ST_DRAIN;
`else
              state_q     <= ST_ISSUE;
              csr_addr_q  <= dec_addr_d;
              csr_write_q <= dec_op;
              csr_wdata_q <= dec_operand;
`endif
            end
          end
        end
        ST_DRAIN: begin
`ifdef CSR_SERIALIZE_EN
          if (req_kill) begin
            state_q     <= ST_IDLE;
            req_ready_q <= 1'b1;
          end else if (pipe_empty) begin
            state_q     <= ST_ISSUE;
            csr_addr_q  <= dec_addr_d;
            csr_write_q <= dec_op;
            csr_wdata_q <= dec_operand;
          end
`else
          state_q     <= ST_IDLE;
          req_ready_q <= 1'b1;
`endif
        end
        ST_ISSUE: begin
          // The CSR file commits at this edge; rdata is the pre-write value.
          state_q     <= ST_RESP;
          csr_addr_q  <= '0;
          csr_write_q <= CSR_NONE;
          csr_wdata_q <= '0;
          rsp_valid_q <= 1'b1;
          if (csr.csr_error) begin
            rsp_exc_q   <= 1'b1;
            rsp_cause_q <= IILLEGAL;
            rsp_tval_q  <= insn_q;
            rsp_rd_q    <= '0;
            rsp_data_q  <= '0;
          end else begin
            rsp_exc_q   <= 1'b0;
            rsp_cause_q <= IMISALIGN;
            rsp_tval_q  <= '0;
            rsp_rd_q    <= insn_q[11:7];
            rsp_data_q  <= csr.csr_rdata;
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            state_q     <= ST_IDLE;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_exc_q   <= 1'b0;
            rsp_cause_q <= IMISALIGN;
            rsp_tval_q  <= '0;
            rsp_rd_q    <= '0;
            rsp_data_q  <= '0;
`ifdef CSR_SERIALIZE_EN
            if (!rsp_exc_q) begin
              flush_q    <= 1'b1;
              flush_pc_q <= pc_q + 30'd1;
            end
`endif
          end
        end
        default: begin
          state_q     <= ST_IDLE;
          req_ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign req_ready     = req_ready_q;
  assign csr.csr_addr  = csr_addr_q;
  assign csr.csr_write = csr_write_q;
  assign csr.csr_wdata = csr_wdata_q;
  assign rsp_valid     = rsp_valid_q;
  assign rsp_rd        = rsp_rd_q;
  assign rsp_data      = rsp_data_q;
  assign rsp_exc       = rsp_exc_q;
  assign rsp_cause     = rsp_cause_q;
  assign rsp_tval      = rsp_tval_q;

`ifdef CSR_SERIALIZE_EN
  assign flush    = flush_q;
  assign flush_pc = flush_pc_q;
`else
  // Without serialisation the drain/refetch inputs have no effect.
  logic unused_serialize_inputs;
  assign unused_serialize_inputs = ^{req_kill, pipe_empty, req_pc};
  assign flush    = 1'b0;
  assign flush_pc = '0;
`endif

endmodule

// File: tb/tb_csr_issue.sv
// Randomised scoreboard bench for csr_issue: a driver computes each expected
// CSR-port operation and response from a register-level model and queues
// them; monitors compare whatever the DUT presents against the queue heads.
module tb_csr_issue;
  import csr_issue_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_insn;
  logic [31:0] req_rs1;
  logic [29:0] req_pc;
  logic        req_kill;
  logic        pipe_empty;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [4:0]  rsp_rd;
  logic [31:0] rsp_data;
  logic        rsp_exc;
  ecause_t     rsp_cause;
  logic [31:0] rsp_tval;
  logic        flush;
  logic [29:0] flush_pc;

  csr_issue_if csr_bus ();

  csr_issue dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_insn   (req_insn),
    .req_rs1    (req_rs1),
    .req_pc     (req_pc),
    .req_kill   (req_kill),
    .pipe_empty (pipe_empty),
    .csr        (csr_bus),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_rd     (rsp_rd),
    .rsp_data   (rsp_data),
    .rsp_exc    (rsp_exc),
    .rsp_cause  (rsp_cause),
    .rsp_tval   (rsp_tval),
    .flush      (flush),
    .flush_pc   (flush_pc)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Implemented CSRs: mstatus, mtvec, mscratch, mepc, cycle (read-only).
  function automatic logic [3:0] csr_idx(input logic [11:0] a);
    case (a)
      12'h300: return 4'd0;
      12'h305: return 4'd1;
      12'h340: return 4'd2;
      12'h341: return 4'd3;
      12'hC00: return 4'd4;
      default: return 4'hF;
    endcase
  endfunction

  // ---------------- CSR file environment (slave side) ----------------
  logic        env_init = 1'b1;
  logic [31:0] env_regs [8];
  logic [3:0]  env_idx;

  always_comb begin
    env_idx               = csr_idx(csr_bus.csr_addr);
    csr_bus.csr_rdata     = (env_idx == 4'hF) ? 32'h0 : env_regs[env_idx[2:0]];
    csr_bus.csr_error     = (env_idx == 4'hF) ||
                            ((csr_bus.csr_write != CSR_NONE) && (csr_bus.csr_addr[11:10] == 2'b11));
  end

  always @(posedge clk) begin
    if (env_init) begin
      env_regs[0] <= 32'h0000_1800;
      env_regs[1] <= 32'h0000_0000;
      env_regs[2] <= 32'h0000_0011;
      env_regs[3] <= 32'h0000_0000;
      env_regs[4] <= 32'h00C0_FFEE;
      env_regs[5] <= 32'h0;
      env_regs[6] <= 32'h0;
      env_regs[7] <= 32'h0;
    end else if (csr_bus.csr_write != CSR_NONE && !csr_bus.csr_error) begin
      case (csr_bus.csr_write)
        CSR_WRITE: env_regs[env_idx[2:0]] <= csr_bus.csr_wdata;
        CSR_SET:   env_regs[env_idx[2:0]] <= env_regs[env_idx[2:0]] | csr_bus.csr_wdata;
        CSR_CLEAR: env_regs[env_idx[2:0]] <= env_regs[env_idx[2:0]] & ~csr_bus.csr_wdata;
        default:   ;
      endcase
    end
  end

  // ---------------- reference model and scoreboard queues ----------------
  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
    logic        exc;
    logic [31:0] tval;
    logic [29:0] pc;
    int          c0;
    int          lat;   // -1: latency not checked
  } rsp_t;

  typedef struct {
    logic [11:0] addr;
    logic [1:0]  op;
    logic [31:0] wdata;
    int          c0;    // -1: timing not checked
  } iss_t;

  rsp_t        rsp_q[$];
  iss_t        iss_q[$];
  logic [31:0] mdl_regs [8];

  logic hold_rsp    = 1'b0;
  logic force_stall = 1'b0;
  logic pe_low      = 1'b0;

  task automatic send(input logic [11:0] csr, input logic [4:0] r1f, input logic [2:0] f3,
                      input logic [4:0] rd, input logic [31:0] rs1v, input logic [29:0] pc);
    logic [31:0] insn;
    logic [31:0] opnd;
    logic [31:0] old;
    logic [3:0]  idx;
    logic        wr;
    rsp_t        e;
    iss_t        s;
    int          w;
    insn = {csr, r1f, f3, rd, 7'b1110011};
    w = 0;
    @(negedge clk);
    while (!req_ready && w < 60) begin
      @(negedge clk);
      w++;
    end
    if (!req_ready) begin
      chk("req_ready_wait", 32'(req_ready), 32'd1);
      return;
    end
    req_valid = 1'b1;
    req_insn  = insn;
    req_rs1   = rs1v;
    req_pc    = pc;
    e.pc  = pc;
    e.c0  = cyc;
    e.rd  = '0;
    e.data = '0;
    e.exc = 1'b1;
    e.tval = insn;
    e.lat = -1;
    if (f3[1:0] != 2'b00) begin
      opnd = f3[2] ? 32'(r1f) : rs1v;
      wr   = (f3[1:0] == 2'b01) || (r1f != 5'd0);
      idx  = csr_idx(csr);
`ifndef CSR_SERIALIZE_EN
      e.lat = 2;
`endif
      if (!(idx == 4'hF || (wr && csr[11:10] == 2'b11))) begin
        old    = mdl_regs[idx[2:0]];
        e.exc  = 1'b0;
        e.rd   = rd;
        e.data = old;
        e.tval = '0;
        if (wr) begin
          if (f3[1:0] == 2'b01) mdl_regs[idx[2:0]] = opnd;
          else if (f3[1:0] == 2'b10) mdl_regs[idx[2:0]] = old | opnd;
          else mdl_regs[idx[2:0]] = old & ~opnd;
        end
      end
      if (wr) begin
        s.addr  = csr;
        s.op    = f3[1:0];
        s.wdata = opnd;
        s.c0    = e.lat < 0 ? -1 : cyc;
        iss_q.push_back(s);
      end
    end
    rsp_q.push_back(e);
    @(negedge clk);
    req_valid = 1'b0;
    req_insn  = $urandom;
    req_rs1   = $urandom;
  endtask

  task automatic drain();
    int w;
    w = 0;
    while ((rsp_q.size() != 0 || iss_q.size() != 0) && w < 200) begin
      @(negedge clk);
      w++;
    end
    chk("drain_pending", 32'(rsp_q.size() + iss_q.size()), 32'd0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_req_ready"}, 32'(req_ready), 32'd1);
    chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
    chk({tag, "_rsp_rd"},    32'(rsp_rd), 32'd0);
    chk({tag, "_rsp_data"},  rsp_data, 32'd0);
    chk({tag, "_rsp_exc"},   32'(rsp_exc), 32'd0);
    chk({tag, "_rsp_cause"}, 32'(rsp_cause), 32'd0);
    chk({tag, "_rsp_tval"},  rsp_tval, 32'd0);
    chk({tag, "_csr_addr"},  32'(csr_bus.csr_addr), 32'd0);
    chk({tag, "_csr_write"}, 32'(csr_bus.csr_write), 32'd0);
    chk({tag, "_csr_wdata"}, csr_bus.csr_wdata, 32'd0);
    chk({tag, "_flush"},     32'(flush), 32'd0);
    chk({tag, "_flush_pc"},  32'(flush_pc), 32'd0);
  endtask

  // ---------------- CSR port monitor ----------------
  always @(negedge clk) begin
    if (!reset && csr_bus.csr_write != CSR_NONE) begin
      if (iss_q.size() == 0) begin
        chk("unexpected_csr_write", 32'(csr_bus.csr_write), 32'd0);
      end else begin
        iss_t s;
        s = iss_q.pop_front();
        chk("csr_addr",  32'(csr_bus.csr_addr), 32'(s.addr));
        chk("csr_write", 32'(csr_bus.csr_write), 32'(s.op));
        chk("csr_wdata", csr_bus.csr_wdata, s.wdata);
        chk("issue_req_ready", 32'(req_ready), 32'd0);
        if (s.c0 >= 0) chk("issue_cycle", 32'(cyc - s.c0), 32'd1);
      end
    end
  end

  // ---------------- response monitor ----------------
  initial begin
    logic        prev_valid;
    int          stall_left;
    int          n_rsp;
    logic        flush_due;
    logic        exp_flush;
    logic [29:0] exp_fpc;
    rsp_t        e;
    prev_valid = 1'b0;
    stall_left = 0;
    n_rsp      = 0;
    flush_due  = 1'b0;
    exp_flush  = 1'b0;
    exp_fpc    = '0;
    rsp_ready  = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev_valid = 1'b0;
        flush_due  = 1'b0;
        rsp_ready  = 1'b0;
        continue;
      end
      if (flush_due) begin
        chk("flush", 32'(flush), 32'(exp_flush));
        if (exp_flush) chk("flush_pc", 32'(flush_pc), 32'(exp_fpc));
        flush_due = 1'b0;
      end else if (flush !== 1'b0) begin
        chk("flush_spurious", 32'(flush), 32'd0);
      end
      if (rsp_valid) begin
        if (rsp_q.size() == 0) begin
          chk("unexpected_rsp_valid", 32'(rsp_valid), 32'd0);
          rsp_ready  = 1'b1;
          prev_valid = 1'b0;
          continue;
        end
        e = rsp_q[0];
        if (!prev_valid) begin
          stall_left  = force_stall ? 5 : $urandom_range(0, 2);
          force_stall = 1'b0;
          if (e.lat >= 0) chk("rsp_latency", 32'(cyc - e.c0), 32'(e.lat));
        end
        // Checked every cycle the response is offered, so a held response must stay stable.
        chk("rsp_exc", 32'(rsp_exc), 32'(e.exc));
        chk("rsp_rd", 32'(rsp_rd), 32'(e.rd));
        chk("rsp_tval", rsp_tval, e.tval);
        if (e.exc) chk("rsp_cause", 32'(rsp_cause), 32'(IILLEGAL));
        else       chk("rsp_data", rsp_data, e.data);
        chk("rsp_req_ready", 32'(req_ready), 32'd0);
        rsp_ready = (stall_left == 0) && !hold_rsp;
        if (rsp_ready) begin
          void'(rsp_q.pop_front());
          n_rsp++;
          $display("rsp %0d: rd=%0d data=%h exc=%0d tval=%h", n_rsp, rsp_rd, rsp_data, rsp_exc, rsp_tval);
          flush_due = 1'b1;
`ifdef CSR_SERIALIZE_EN
          exp_flush = !e.exc;
`else
          exp_flush = 1'b0;
`endif
          exp_fpc    = e.pc + 30'd1;
          prev_valid = 1'b0;
        end else begin
          if (stall_left > 0) stall_left--;
          prev_valid = 1'b1;
        end
      end else begin
        rsp_ready  = 1'b0;
        prev_valid = 1'b0;
      end
    end
  end

  // pipe_empty is only honoured by the serialising build.
  initial begin
    pipe_empty = 1'b0;
    forever begin
      @(negedge clk);
      pipe_empty = pe_low ? 1'b0 : ($urandom_range(0, 2) == 0);
    end
  end

  // ---------------- main stimulus ----------------
  initial begin
    int w;
    logic [11:0] addrs [6];
    addrs[0] = 12'h300; addrs[1] = 12'h305; addrs[2] = 12'h340;
    addrs[3] = 12'h341; addrs[4] = 12'hC00; addrs[5] = 12'h7C0;
    mdl_regs[0] = 32'h0000_1800;
    mdl_regs[1] = 32'h0;
    mdl_regs[2] = 32'h0000_0011;
    mdl_regs[3] = 32'h0;
    mdl_regs[4] = 32'h00C0_FFEE;
    mdl_regs[5] = 32'h0;
    mdl_regs[6] = 32'h0;
    mdl_regs[7] = 32'h0;
    reset     = 1'b1;
    req_valid = 1'b0;
    req_insn  = '0;
    req_rs1   = '0;
    req_pc    = '0;
    req_kill  = 1'b0;
    @(negedge clk);
    chk_reset_outputs("reset");
    @(negedge clk);
    @(negedge clk);
    reset    = 1'b0;
    env_init = 1'b0;

    // Directed cases.
    send(12'h340, 5'd7, F3_CSRRW, 5'd5, 32'hDEADBEEF, 30'h100);   // write mscratch
    send(12'h300, 5'd0, F3_CSRRS, 5'd3, 32'hFFFF_FFFF, 30'h101);  // pure read mstatus
    send(12'h300, 5'd8, F3_CSRRCI, 5'd1, 32'h0, 30'h102);         // clear MIE via uimm
    send(12'h340, 5'd0, F3_CSRRC, 5'd0, 32'h0, 30'h103);          // read to x0
    send(12'hC00, 5'd4, F3_CSRRW, 5'd2, 32'h1234_5678, 30'h104);  // read-only write -> error
    force_stall = 1'b1;
    send(12'h305, 5'd3, F3_CSRRSI, 5'd6, 32'h0, 30'h105);         // response held 5 cycles
    send(12'h341, 5'd9, 3'b000, 5'd4, 32'h0, 30'h106);            // illegal funct3 000
    send(12'h341, 5'd9, 3'b100, 5'd4, 32'h0, 30'h107);            // illegal funct3 100
    send(12'hC00, 5'd0, F3_CSRRS, 5'd8, 32'h0, 30'h108);          // read-only pure read is fine

    // Random traffic.
    for (int i = 0; i < 150; i++) begin
      send(addrs[$urandom_range(0, 5)],
           ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom),
           3'($urandom),
           5'($urandom),
           $urandom,
           30'($urandom));
    end
    drain();

    // Reset while a response is pending: response is dropped, outputs clear.
    hold_rsp = 1'b1;
    send(12'h341, 5'd2, F3_CSRRW, 5'd9, 32'hCAFE_0001, 30'h200);
    w = 0;
    while (!rsp_valid && w < 20) begin
      @(negedge clk);
      w++;
    end
    chk("pre_reset_rsp_valid", 32'(rsp_valid), 32'd1);
    #1 reset = 1'b1;
    #1 chk_reset_outputs("midrsp_reset");
    rsp_q.delete();
    iss_q.delete();
    @(negedge clk);
    reset    = 1'b0;
    hold_rsp = 1'b0;
    send(12'h341, 5'd0, F3_CSRRS, 5'd10, 32'h0, 30'h201);         // committed write is visible

`ifdef CSR_SERIALIZE_EN
    // Kill while draining: no CSR access, no response.
    drain();
    pe_low = 1'b1;
    @(negedge clk);
    req_valid = 1'b1;
    req_insn  = {12'h341, 5'd1, F3_CSRRW, 5'd3, 7'b1110011};
    req_rs1   = 32'hBAD0_BAD0;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    req_kill = 1'b1;
    @(negedge clk);
    req_kill = 1'b0;
    repeat (4) @(negedge clk);
    chk("kill_no_rsp", 32'(rsp_valid), 32'd0);
    chk("kill_req_ready", 32'(req_ready), 32'd1);
    pe_low = 1'b0;
    send(12'h341, 5'd0, F3_CSRRS, 5'd11, 32'h0, 30'h202);
`endif

    drain();
    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
